// File: rtl/llki_mock_tss_gen.sv
// Parametrised mock TSS: collects KEY_WORDS masked key words over the
// LLKI-Discrete handshake, un-masks each word with its own XOR mask,
// inserts wait states after every word and every clear, and drives the
// unlocked key into the wrapped core once the whole key has arrived.
module llki_mock_tss_gen #(
  parameter int                            KEY_WORDS         = 2,
  parameter int                            DATA_W            = 64,
  parameter logic [7:0]                    WAIT_STATES       = 8'h0A,
  parameter logic [7:0]                    CLEAR_WAIT_STATES = 8'h0A,
  parameter logic [KEY_WORDS*DATA_W-1:0]   KEY_MASK          = {64'hFEDCBA9876543210, 64'h0123456789ABCDEF}
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA_W-1:0]                  llkid_key_data,
  input  logic                               llkid_key_valid,
  output logic                               llkid_key_ready,
  output logic                               llkid_key_complete,
  input  logic                               llkid_clear_key,
  output logic                               llkid_clear_key_ack,
  output logic [KEY_WORDS*DATA_W-1:0]        tss_key,
  output logic [$clog2(KEY_WORDS+1)-1:0]     tss_word_idx
);

  localparam int IDX_W = $clog2(KEY_WORDS + 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT       = 2'd1,
    S_CLEAR      = 2'd2,
    S_CLEAR_HOLD = 2'd3
  } state_t;

  state_t                      state;
  logic [7:0]                  ctr;
  logic [KEY_WORDS*DATA_W-1:0] key_flat;
  logic                        accept;
  logic                        clear_start;

  // A word is taken only in IDLE with ready high; a simultaneous clear wins.
  assign accept = (state == S_IDLE) && !llkid_clear_key && llkid_key_valid &&
                  llkid_key_ready && (tss_word_idx < IDX_W'(KEY_WORDS));

  // Clear can start from IDLE or WAIT; CLEAR/CLEAR_HOLD already own the request.
  assign clear_start = llkid_clear_key && ((state == S_IDLE) || (state == S_WAIT));

  generate
    for (genvar gi = 0; gi < KEY_WORDS; gi++) begin : g_word
      logic [DATA_W-1:0] word_reg;

      assign key_flat[gi*DATA_W +: DATA_W] = word_reg;

      // Per-word key register: loaded un-masked when its slot is the next to fill.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_reg <= '0;
        end else if (clear_start) begin
          word_reg <= '0;
        end else if (accept && (tss_word_idx == IDX_W'(gi))) begin
          word_reg <= llkid_key_data ^ KEY_MASK[gi*DATA_W +: DATA_W];
        end
      end
    end
  endgenerate

  // Control FSM with registered handshake, status and key outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      ctr                 <= '0;
      tss_word_idx        <= '0;
      llkid_key_ready     <= 1'b0;
      llkid_key_complete  <= 1'b0;
      llkid_clear_key_ack <= 1'b0;
      tss_key             <= '0;
    end else begin
      llkid_clear_key_ack <= 1'b0;
      if (clear_start) begin
        // Drop everything loaded so far and relock the core immediately.
        state              <= S_CLEAR;
        ctr                <= CLEAR_WAIT_STATES;
        tss_word_idx       <= '0;
        llkid_key_ready    <= 1'b0;
        llkid_key_complete <= 1'b0;
        tss_key            <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              state           <= S_WAIT;
              ctr             <= WAIT_STATES;
              tss_word_idx    <= tss_word_idx + IDX_W'(1);
              llkid_key_ready <= 1'b0;
            end else begin
              llkid_key_ready <= !llkid_key_complete;
            end
          end
          S_WAIT: begin
            if (ctr != 8'd0) begin
              ctr <= ctr - 8'd1;
            end else begin
              state <= S_IDLE;
              if (tss_word_idx == IDX_W'(KEY_WORDS)) begin
                // Last word's wait is over: expose the key, stop accepting.
                llkid_key_complete <= 1'b1;
                tss_key            <= key_flat;
                llkid_key_ready    <= 1'b0;
              end else begin
                llkid_key_ready <= 1'b1;
              end
            end
          end
          S_CLEAR: begin
            if (ctr != 8'd0) begin
              ctr <= ctr - 8'd1;
            end else begin
              llkid_clear_key_ack <= 1'b1;
              state               <= S_CLEAR_HOLD;
            end
          end
          S_CLEAR_HOLD: begin
            // One ack per request level: wait for the request to drop.
            if (!llkid_clear_key) begin
              state           <= S_IDLE;
              llkid_key_ready <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
